// File: rtl/resource_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | resource_arb_pkg: shared types and round-robin pick for resource_arbiter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package resource_arb_pkg;

  localparam int c_MAX_REQ = 8;
  localparam int c_OWNER_W = $clog2(c_MAX_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [c_OWNER_W-1:0] owner;
  } tag_t;

  typedef struct packed {
    logic                 found;
    logic [c_OWNER_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping within num requesters.
  function automatic pick_t rr_pick(input logic [c_MAX_REQ-1:0] req,
                                    input logic [c_OWNER_W-1:0] ptr,
                                    input int                   num);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = c_MAX_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % num;
      if (k < num && req[idx]) begin
        r.found = 1'b1;
        r.idx   = c_OWNER_W'(idx);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/resource_arbiter_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_tag_pipe: owner tag shift register aligned to resource latency,   |
// | with per-requester flush kill on every stage including the head.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module result_tag_pipe
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic [c_OWNER_W-1:0] push_owner,
  input  logic [NUM_REQ-1:0]   flush,
  output tag_t                 head
);

  tag_t                 r_stage [DEPTH];
  logic [DEPTH-1:0]     w_kill;
  logic [c_MAX_REQ-1:0] w_flush;

  assign w_flush = c_MAX_REQ'(flush);

  always_comb begin
    w_kill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_kill[k] = w_flush[r_stage[k].owner];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= '{valid: push_valid, owner: push_owner};
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k].valid <= r_stage[k-1].valid & ~w_kill[k-1];
        r_stage[k].owner <= r_stage[k-1].owner;
      end
    end
  end

  // A flush arriving on the read cycle still suppresses the response.
  always_comb begin
    head       = r_stage[DEPTH-1];
    head.valid = r_stage[DEPTH-1].valid & ~w_kill[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/resource_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | resource_arbiter: round-robin sharing of one fixed-latency resource with |
// | a hold limit, owner tagging and one-hot result routing.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module resource_arbiter
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int RES_LATENCY = 2,
  parameter int MAX_HOLD    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        flush,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         res_in,
  output logic                      res_in_valid,
  input  logic [DATA_W-1:0]         res_out,
  output logic [DATA_W-1:0]         resp_data,
  output logic [NUM_REQ-1:0]        resp_valid
);

  localparam int                   c_HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_OWNER_W-1:0] c_LAST     = c_OWNER_W'(NUM_REQ - 1);

  state_t               r_state,  w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant,  w_grant_nxt;
  logic [c_OWNER_W-1:0] r_owner,  w_owner_nxt;
  logic [c_OWNER_W-1:0] r_ptr,    w_ptr_nxt;
  logic [c_HOLD_W-1:0]  r_hold,   w_hold_nxt;
  logic [c_HOLD_W-1:0]  w_hold_inc;
  logic [c_OWNER_W-1:0] w_owner_plus;
  logic                 w_issue;
  logic                 w_release;
  pick_t                w_pick;
  tag_t                 w_head;

  assign w_issue      = (r_state == GRANT) && |(r_grant & req & ~flush);
  assign w_hold_inc   = (w_issue && r_hold != c_HOLD_MAX) ? r_hold + c_HOLD_W'(1) : r_hold;
  assign w_owner_plus = (r_owner == c_LAST) ? '0 : r_owner + c_OWNER_W'(1);

  // Hold limit counts the current beat, so the owner gets exactly MAX_HOLD beats.
  assign w_release = !(|(req & r_grant)) || (|(flush & r_grant)) ||
                     ((w_hold_inc == c_HOLD_MAX) && |(req & ~r_grant));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_pick      = rr_pick(c_MAX_REQ'(req), r_ptr, NUM_REQ);
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick.idx;
          w_grant_nxt = NUM_REQ'(1) << w_pick.idx;
          w_hold_nxt  = '0;
        end
      end
      GRANT: begin
        w_hold_nxt = w_hold_inc;
        if (w_release) begin
          // Hand over in the same cycle so there is no bubble between owners.
          w_ptr_nxt  = w_owner_plus;
          w_hold_nxt = '0;
          w_pick     = rr_pick(c_MAX_REQ'(req & ~r_grant), w_owner_plus, NUM_REQ);
          if (w_pick.found) begin
            w_owner_nxt = w_pick.idx;
            w_grant_nxt = NUM_REQ'(1) << w_pick.idx;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    res_in = '0;
    if (w_issue) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant[i]) res_in = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign res_in_valid = w_issue;
  assign grant        = r_grant;

  result_tag_pipe #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (RES_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (w_issue),
    .push_owner (r_owner),
    .flush      (flush),
    .head       (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= '0;
      if (w_head.valid) begin
        resp_valid <= NUM_REQ'(1) << w_head.owner;
        resp_data  <= res_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
- Shares one fixed-latency resource between NUM_REQ pipeline_top instances.
- Consumes each instance's arbiter_req / resource_input and drives its arbiter_grant.
- Issues granted data to the resource, tags each issue with its owner, and routes the result (resource_output) back one-hot.
- Round-robin fairness, with a hold limit so one streaming requester cannot starve the others.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, data width to/from the resource
- RES_LATENCY, 2, cycles from res_in_valid to the matching res_out (>=1)
- MAX_HOLD, 4, max consecutive issue beats per ownership while others are waiting

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- req  in  NUM_REQ  per-requester arbiter_req
- req_data  in  NUM_REQ*DATA_W  per-requester resource_input; slice i = bits [i*DATA_W +: DATA_W]
- flush  in  NUM_REQ  per-requester flush; kills that requester's grant and in-flight results
- grant  out  NUM_REQ  one-hot or zero, registered; drives arbiter_grant
- res_in  out  DATA_W  data to resource
- res_in_valid  out  1  issue strobe to resource
- res_out  in  DATA_W  resource result, valid exactly RES_LATENCY cycles after issue
- resp_data  out  DATA_W  registered result
- resp_valid  out  NUM_REQ  one-hot registered result strobe to owner

Behaviour:
- Reset (reset low, async) clears everything:
  - grant=0, res_in_valid=0, res_in=0, resp_valid=0, resp_data=0
  - rr pointer=0, hold count=0, tag pipe empty, state IDLE
- Issue rule:
  - Issue in cycle t iff grant[i] && req[i] && !flush[i].
  - On issue: res_in_valid=1 and res_in=req_data slice i (combinational from registered grant).
  - Otherwise res_in_valid=0 and res_in=0.
- Tag pipe: RES_LATENCY-deep shift register of {valid, owner index}, pushed every cycle.
  - When the head is valid, resp_valid[owner] and resp_data<=res_out are registered next edge.
  - Issue-to-resp latency = RES_LATENCY+1 cycles.
- Flush:
  - flush[i] clears valid on every tag-pipe entry owned by i in that same cycle, so no resp_valid[i] is produced for them.
  - A flush in the same cycle the head is read suppresses that response too.
- FSM, IDLE:
  - grant=0.
  - If any req: owner = first set bit of req at or after the pointer, scanning upward with wrap. Set grant[owner] next edge, hold=0, go to GRANT.
- FSM, GRANT (owner o):
  - hold increments on each issue, saturating at MAX_HOLD.
  - Release o when: !req[o], or flush[o], or (hold==MAX_HOLD and any other req set).
  - On release: pointer <= o+1 mod NUM_REQ, and the next owner is chosen in the same cycle from req excluding o.
  - If a next owner exists, grant moves to it with no idle cycle (zero bubble), hold=0. Otherwise go to IDLE, grant=0.
  - If hold==MAX_HOLD and no other req: o keeps grant and hold stays saturated.
- Grant is always at most one-hot. At most one issue per cycle.
- Simultaneous events:
  - flush[o] with req[o] high: no issue, release o.
  - A req rising in the same cycle as a release is eligible for that release's selection.
- A requester dropping req while in-flight results exist still receives them (unless flushed).
- Reset mid-operation: in-flight results are discarded; late res_out is ignored.

Decomposition:
- Shared package resource_arb_pkg:
  - state enum {IDLE, GRANT}
  - tag struct {valid, owner[$clog2(NUM_REQ)-1:0]}
  - function rr_pick(req, ptr) returning index and found flag
- One sub-module, result_tag_pipe: the tag shift register with flush-kill and head output.

Test Plan:
- Single requester: req=4'b0001, req_data0=32'h11 for 3 cycles. Expect grant=0001 one cycle after req, res_in_valid for 3 cycles with res_in=32'h11, resp_valid=0001 each 3 cycles after its issue.
- Round robin: req=1111 held, MAX_HOLD=4. Expect grant sequence 0001(4 beats), 0010(4), 0100(4), 1000(4), 0001, with no bubble between owners.
- Hold saturation: only req[2] high for 10 cycles. Expect grant=0100 continuously and 10 issues. Raise req[3] at cycle 10; grant moves to 1000 on the next edge.
- Flush kill: owner 1 issues 32'hA, 32'hB, then flush[1] one cycle later. Expect grant drops, neither response produced, owner 0 (if requesting) granted with zero bubble.
- Result routing: alternate owners 0 and 3 with data 32'h5/32'h6 and res_out=data+1. Expect resp_valid 0001 with 32'h6, then 1000 with 32'h7, in order.
- Async reset mid-stream: assert reset low between clock edges with results in flight. Expect all outputs 0 immediately, no resp_valid after deassertion, and the first grant after release going to requester 0.
